// File: rtl/dram_bist_master_pkg.sv
// Shared types, constants and the expected-pattern function for the data-memory BIST master.
package dram_bist_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        FIN
    } state_t;

    localparam logic [7:0] ERR_SAT = 8'd255;
    localparam int         PAT_W   = 8;

    // Address and data share one width so the pattern can be formed as addr ^ seed.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                 input logic [PAT_W-1:0] seed,
                                                 input logic             invert);
        return invert ? ~(addr ^ seed) : (addr ^ seed);
    endfunction

endpackage

// File: rtl/dram_bist_master_if.sv
// Data-memory port (ADDR/DATA/MW/Q) shared by the CPU and the BIST master.
interface dram_bist_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA;
    logic          MW;
    logic [DW-1:0] Q;

    modport master (output ADDR, output DATA, output MW, input  Q);
    modport slave  (input  ADDR, input  DATA, input  MW, output Q);
endinterface

// File: rtl/dram_bist_master_bist_addr_walker.sv
// Address window walker: holds the latched window bounds and steps a wrapping address counter.
module dram_bist_master_bist_addr_walker #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          load,
    input  logic          restart,
    input  logic          step,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] addr,
    output logic          is_last
);

    logic [AW-1:0] base_q;
    logic [AW-1:0] last_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q <= '0;
            last_q <= '0;
            addr   <= '0;
        end else if (load) begin
            base_q <= base_addr;
            last_q <= last_addr;
            addr   <= base_addr;
        end else if (restart) begin
            addr   <= base_q;
        end else if (step) begin
            addr   <= addr + 1'b1;
        end
    end

    assign is_last = (addr == last_q);

endmodule

// File: rtl/dram_bist_master.sv
// BIST initiator for the data-memory port: write/read-compare of a seeded pattern, then its inverse.
//
// state | meaning
// IDLE  | waiting for START; memory port driven to zero
// WR0   | write P0 = addr ^ seed, one address per cycle
// RD0   | per address: issue read, count down READ_LATENCY, compare against P0
// WR1   | write P1 = ~(addr ^ seed)
// RD1   | read back and compare against P1
// FIN   | one cycle; latch DONE and PASS
module dram_bist_master
    import dram_bist_master_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int AW           = 8,
    parameter int DW           = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [AW-1:0]       BASE_ADDR,
    input  logic [AW-1:0]       LAST_ADDR,
    input  logic [DW-1:0]       SEED,
    dram_bist_master_if.master  mem,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [7:0]          ERR_COUNT,
    output logic [AW-1:0]       FAIL_ADDR,
    output logic [DW-1:0]       FAIL_DATA
);

    localparam logic [2:0] RL_CNT = 3'(READ_LATENCY);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          restart;
    logic          step;
    logic [AW-1:0] cur_addr;
    logic          is_last;
    logic [DW-1:0] seed_q;
    logic [2:0]    rd_cnt;
    logic          rd_phase;
    logic          cmp_en;
    logic          mismatch;
    logic [DW-1:0] expected;

    dram_bist_master_bist_addr_walker #(.AW(AW)) u_bist_addr_walker (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (load),
        .restart   (restart),
        .step      (step),
        .base_addr (BASE_ADDR),
        .last_addr (LAST_ADDR),
        .addr      (cur_addr),
        .is_last   (is_last)
    );

    assign rd_phase = (state == RD0) || (state == RD1);
    // rd_cnt is loaded with READ_LATENCY on the issue cycle; Q is valid when it reaches zero.
    assign cmp_en   = rd_phase && (rd_cnt == 3'd0);
    assign expected = pattern(cur_addr, seed_q, (state == WR1) || (state == RD1));
    assign mismatch = cmp_en && (mem.Q != expected);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        restart   = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load      = 1'b1;
                    state_nxt = WR0;
                end
            end
            WR0, WR1: begin
                if (is_last) begin
                    restart   = 1'b1;
                    state_nxt = (state == WR0) ? RD0 : RD1;
                end else begin
                    step = 1'b1;
                end
            end
            RD0, RD1: begin
                if (cmp_en) begin
                    if (is_last) begin
                        restart   = 1'b1;
                        state_nxt = (state == RD0) ? WR1 : FIN;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state != IDLE);
        mem.MW   = (state == WR0) || (state == WR1);
        mem.ADDR = ((state == IDLE) || (state == FIN)) ? '0 : cur_addr;
        mem.DATA = mem.MW ? expected : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_cnt <= RL_CNT;
        end else if (rd_phase && (rd_cnt != 3'd0)) begin
            rd_cnt <= rd_cnt - 3'd1;
        end else begin
            rd_cnt <= RL_CNT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            seed_q    <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_COUNT <= '0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
        end else begin
            if (load) begin
                seed_q    <= SEED;
                DONE      <= 1'b0;
                PASS      <= 1'b0;
                ERR_COUNT <= '0;
                FAIL_ADDR <= '0;
                FAIL_DATA <= '0;
            end else if (mismatch) begin
                if (ERR_COUNT != ERR_SAT) begin
                    ERR_COUNT <= ERR_COUNT + 8'd1;
                end
                // ERR_COUNT saturates and never returns to zero, so zero marks the first mismatch.
                if (ERR_COUNT == 8'd0) begin
                    FAIL_ADDR <= cur_addr;
                    FAIL_DATA <= mem.Q;
                end
            end
            if (state == FIN) begin
                DONE <= 1'b1;
                PASS <= (ERR_COUNT == 8'd0);
            end
        end
    end

endmodule

// File: doc/dram_bist_master.md
Name: dram_bist_master

Overview:
Built-in self-test initiator for the data-memory port. It drives the same ADDR/DATA/MW/Q interface that the CPU drives into data RAM, acting as the master where the RAM is the responder. On START it writes a seeded pattern over an address window, reads it back and compares, then writes and checks the inverted pattern. Results are captured in status outputs. A top-level mux selects this block over the CPU while BUSY=1.

Parameters:
READ_LATENCY, 1, cycles from ADDR presented (MW=0) to Q valid; legal range 1..4.
AW, 8, address width.
DW, 8, data width.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  begin test; sampled only in IDLE.
BASE_ADDR  input  AW  first address of window; latched at START.
LAST_ADDR  input  AW  last address of window (inclusive); latched at START.
SEED  input  DW  pattern seed; latched at START.
ADDR  output  AW  memory address.
DATA  output  DW  write data.
MW  output  1  memory write enable; RAM samples ADDR/DATA on the CLK edge while MW=1.
Q  input  DW  memory read data.
BUSY  output  1  test in progress; also the mux select for the memory port.
DONE  output  1  level; set when the test completes, cleared by the next accepted START or by RESET.
PASS  output  1  valid while DONE=1; 1 when ERR_COUNT=0.
ERR_COUNT  output  8  mismatch count, saturating at 255.
FAIL_ADDR  output  AW  address of the first mismatch.
FAIL_DATA  output  DW  Q value at the first mismatch.

Behaviour:
- Reset values: ADDR=0, DATA=0, MW=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FAIL_ADDR=0, FAIL_DATA=0, state IDLE.
- Reset mid-operation: next cycle all outputs hold reset values. No partial write is issued after the reset edge.
- Window: starts at BASE and increments modulo 2^AW until the address equals LAST.
  - N = (LAST - BASE) mod 256, plus 1.
  - BASE=LAST gives N=1. LAST=BASE-1 gives N=256.
- Expected pattern: P0(a) = a XOR SEED. P1(a) = ~(a XOR SEED).
- States:
  - IDLE: START=1 latches inputs, clears DONE/ERR_COUNT/FAIL_*, and moves to WR0. BUSY=1 from the next cycle.
  - WR0: one address per cycle with MW=1 and DATA=P0(ADDR). After LAST, go to RD0.
  - RD0: per address, issue cycle (MW=0, ADDR=a), then wait READ_LATENCY-1 cycles. Compare Q to P0(a) in the cycle Q is valid. After LAST is compared, go to WR1.
  - WR1: as WR0 with P1. Then RD1: as RD0 with P1. Then FIN.
  - FIN: one cycle; sets DONE=1 and PASS=(ERR_COUNT==0). BUSY=0 in the following cycle, return to IDLE.
- Cycle count: BUSY stays high for exactly 2N + 2N(1+READ_LATENCY) + 1 cycles, including FIN.
- Outside write cycles: MW=0. In IDLE: ADDR=0, DATA=0.
- Mismatch handling:
  - ERR_COUNT increments by 1 per mismatch and saturates at 255.
  - FAIL_ADDR/FAIL_DATA are written only on the first mismatch after START.
- START while BUSY, or while in FIN, is ignored. START in IDLE with DONE=1 begins a new test.
- The caller must choose a window that excludes memory-mapped IO addresses. The block does not check this.

Decomposition:
- Shared package: state enum (IDLE, WR0, RD0, WR1, RD1, FIN), the ERR_SAT=255 constant, and the pattern function (addr, seed, invert).
- One natural sub-module: bist_addr_walker.
  - Holds the latched BASE/LAST, the modulo-256 address counter and the last-address flag.
  - Restarts on a phase change.
  - The FSM and compare logic live in the top.

Test Plan:
1. Ideal RAM model with READ_LATENCY=1; BASE=0x10, LAST=0x13, SEED=0xA5 -> WR0 writes 0x10:B5, 0x11:B4, 0x12:B7, 0x13:B6. BUSY high 25 cycles; DONE=1, PASS=1, ERR_COUNT=0.
2. Same window, RAM model with address 0x12 bit0 stuck at 0 -> RD0 reads 0xB6 against expected 0xB7; RD1 expected 0x48 matches. FAIL_ADDR=0x12, FAIL_DATA=0xB6, ERR_COUNT=1, PASS=0.
3. Wrap window BASE=0xFE, LAST=0x01 -> writes hit FE, FF, 00, 01 in that order. BUSY 25 cycles, PASS=1.
4. BASE=0x00, LAST=0xFF, SEED=0x00, Q tied to 0x00 -> N=256 and 1537 BUSY cycles. 510 mismatches, so ERR_COUNT saturates at 255; FAIL_ADDR=0x01, FAIL_DATA=0x00.
5. RESET asserted during WR0 at the third address -> next cycle MW=0, BUSY=0, DONE=0, ERR_COUNT=0. START pulses during BUSY in a fresh run leave the timing of test 1 unchanged.
6. READ_LATENCY=2 with the window and seed of test 1 -> BUSY 33 cycles, PASS=1. Compare happens in the second cycle after each read issue.
